v_pipe_query_mp: RTL and testbench
==================================

Name: v_pipe_query_mp

Overview:
Multi-channel, parametrised successor to the single-port list query pipeline. QUERY_N independent query channels are round-robin arbitrated onto the single state-table read port. Each query is hazard-checked against a configurable-depth update pipeline, and the selected entry's key, volume and listsize are returned with a typed error code. The block sits between the client query buses and the state table, alongside the update pipeline.

Parameters:
QUERY_N, 2, number of query channels (1..8)
UPD_STAGES_N, 4, number of update-pipeline stages exposed for hazard compare (>=1)
BUSY_STALL, 0, 0: a busy hit at S0 returns error BUSY; 1: a busy hit at S0 holds off the grant (channel ready low) until the hazard clears
OUT_REG, 0, 1: register all response outputs (adds one cycle of latency)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_lut_vld  in  QUERY_N  per-channel query request
i_lut_prod_id  in  QUERY_N x $bits(v_pkg::id_t)  per-channel product id
i_lut_level  in  QUERY_N x $bits(v_pkg::level_t)  per-channel level
o_lut_rdy  out  QUERY_N  one-hot grant; query accepted when vld&rdy
o_lut_vld_r  out  1  response valid
o_lut_ch_r  out  $clog2(QUERY_N) (min 1)  channel index of the response
o_lut_key  out  $bits(v_pkg::key_t)  entry key
o_lut_size  out  $bits(v_pkg::volume_t)  entry volume
o_lut_listsize  out  $bits(v_pkg::listsize_t)  list occupancy
o_lut_error  out  1  OR of all error causes
o_lut_err_code  out  $bits(v_pkg::lut_err_t)  NONE / BUSY / INVALID
o_state_ren  out  1  state-table read enable
o_state_raddr  out  $bits(v_pkg::addr_t)  state-table read address
i_state_rdata  in  $bits(v_pkg::state_t)  read data, one cycle after ren
i_upd_vld_r  in  UPD_STAGES_N  per-stage update valid; index 0 = youngest stage
i_upd_prod_id_r  in  UPD_STAGES_N x $bits(v_pkg::id_t)  per-stage update id

Behaviour:
- Reset: o_lut_vld_r=0, o_lut_rdy=0, o_state_ren=0, RR pointer=0, o_lut_err_code=NONE. Data outputs are don't-care while vld=0.
- S0 per-channel busy_c = OR over k of (i_upd_vld_r[k] & i_upd_prod_id_r[k]==i_lut_prod_id[c]).
- Eligibility: eligible_c = i_lut_vld[c] & ~(BUSY_STALL & busy_c).
- Arbitration:
  - Grant the first eligible channel at or after the RR pointer, wrapping modulo QUERY_N.
  - o_lut_rdy = grant; at most one bit set per cycle. rdy is combinational and is forced 0 while rst.
  - On a grant, the pointer moves to (granted+1) mod QUERY_N. With no grant, the pointer holds.
  - QUERY_N=1 degenerates to a pass-through: rdy=eligible.
- On grant: o_state_ren=1 and o_state_raddr=granted prod_id. Latch channel, prod_id, one-hot level decode (ENTRIES_N wide) and busy_s0 into S1 flops, enabled on grant.
- S1 (with OUT_REG=0, one cycle after grant):
  - o_lut_vld_r=1.
  - key and volume are selected from i_state_rdata by the decoded level (one-hot mux). listsize = i_state_rdata.listsize.
  - invalid = (level_dec & rdata.vld)==0.
  - was_busy = i_upd_vld_r[0] & (i_upd_prod_id_r[0]==s1_prod_id). This catches an update that entered the update pipeline in the grant cycle; it applies in both modes.
  - err_code priority: BUSY (busy_s0 | was_busy) > INVALID > NONE. o_lut_error = err_code!=NONE.
- OUT_REG=1: all S1 outputs are registered; response latency is 2 cycles. Throughput is unchanged at one query per cycle.
- A back-to-back grant every cycle must be sustained with no bubbles.
- Requester contract: a held request keeps prod_id/level stable until granted. Dropping vld before grant is legal; no response is produced.
- rst asserted mid-flight: any in-flight S1/OUT_REG response is squashed (vld_r=0 next cycle), and the pointer returns to 0.

Decomposition:
- v_pkg gains lut_err_t (2-bit enum: NONE=0, BUSY=1, INVALID=2). id_t, level_t, key_t, volume_t, listsize_t, addr_t, state_t and cfg_pkg::ENTRIES_N are reused unchanged.
- One natural sub-module: v_rr_arb (parametrised N-way round-robin arbiter with rotating pointer, enable input, one-hot grant output).
- Existing dec and mux primitives are reused for level decode and entry select.

Test Plan:
- QUERY_N=2, ch0 only: id=5, level=3, entry 3 valid with key=0xA, volume=7, listsize=4 -> one cycle later: vld_r=1, ch_r=0, key=0xA, size=7, listsize=4, err_code=NONE.
- Both channels requesting continuously for 4 cycles, pointer at 0 -> grants 0,1,0,1; responses every cycle with ch_r 0,1,0,1.
- BUSY_STALL=0, i_upd_vld_r[2]=1 with id=5, query id=5 -> granted; err_code=BUSY, o_lut_error=1.
- BUSY_STALL=1, same hazard held for 3 cycles on ch0 while ch1 requests id=9 -> ch1 granted each cycle and ch0 rdy=0. Hazard clears -> ch0 granted next cycle and responds with NONE.
- Query id=5 granted while i_upd_vld_r[0] rises with id=5 in the same cycle -> next-cycle response err_code=BUSY. Query to level 2 with rdata.vld bit 2=0 -> err_code=INVALID.
- OUT_REG=1: response arrives 2 cycles after grant. Assert rst the cycle after grant -> no vld_r is produced, and the next grant starts from ch0.

Source files
------------

// File: rtl/v_pipe_query_mp_pkg.sv
// Shared types for the multi-channel list query pipeline: state-table entry
// layout, query error codes and the level decode / entry select helpers.
package v_pipe_query_mp_pkg;

  localparam int ENTRIES_N = 4;
  localparam int ID_W      = 8;
  localparam int LEVEL_W   = 2;
  localparam int KEY_W     = 8;
  localparam int VOL_W     = 8;
  localparam int LS_W      = 4;

  typedef logic [ID_W-1:0]    id_t;
  typedef logic [LEVEL_W-1:0] level_t;
  typedef logic [KEY_W-1:0]   key_t;
  typedef logic [VOL_W-1:0]   volume_t;
  typedef logic [LS_W-1:0]    listsize_t;
  typedef id_t                addr_t;

  typedef struct packed {
    listsize_t                   listsize;
    logic [ENTRIES_N-1:0]        vld;
    key_t    [ENTRIES_N-1:0]     key;
    volume_t [ENTRIES_N-1:0]     vol;
  } state_t;

  typedef enum logic [1:0] {
    LUT_ERR_NONE    = 2'd0,
    LUT_ERR_BUSY    = 2'd1,
    LUT_ERR_INVALID = 2'd2
  } lut_err_t;

  function automatic logic [ENTRIES_N-1:0] level_decode(input level_t lvl);
    level_decode = {{(ENTRIES_N-1){1'b0}}, 1'b1} << lvl;
  endfunction

  // One-hot AND-OR select; an all-zero select yields zero.
  function automatic key_t key_select(input state_t st, input logic [ENTRIES_N-1:0] sel);
    key_select = '0;
    for (int e = 0; e < ENTRIES_N; e++) begin
      key_select = key_select | (st.key[e] & {KEY_W{sel[e]}});
    end
  endfunction

  function automatic volume_t vol_select(input state_t st, input logic [ENTRIES_N-1:0] sel);
    vol_select = '0;
    for (int e = 0; e < ENTRIES_N; e++) begin
      vol_select = vol_select | (st.vol[e] & {VOL_W{sel[e]}});
    end
  endfunction

endpackage

// File: rtl/v_pipe_query_mp_rr_arb.sv
// N-way round-robin arbiter: grants the first request at or after the pointer
// and moves the pointer just past the winner.
module v_rr_arb #(
  parameter  int N  = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o
);

  logic [PW-1:0] ptr_q, ptr_d;
  int            best_s;
  int            best_dist_s;
  int            dist_s;

  // Smallest rotational distance from the pointer wins.
  always_comb begin
    best_s      = 0;
    best_dist_s = N;
    dist_s      = 0;
    for (int j = 0; j < N; j++) begin
      dist_s = j - int'(ptr_q);
      if (dist_s < 0) begin
        dist_s = dist_s + N;
      end else begin
        dist_s = dist_s;
      end
      if (en_i && req_i[j] && (dist_s < best_dist_s)) begin
        best_dist_s = dist_s;
        best_s      = j;
      end else begin
        best_dist_s = best_dist_s;
      end
    end
    for (int j = 0; j < N; j++) begin
      gnt_o[j] = (best_dist_s < N) && (best_s == j);
    end
    if (best_dist_s < N) begin
      ptr_d = (best_s == N - 1) ? '0 : PW'(best_s + 1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/v_pipe_query_mp.sv
// Multi-channel list query pipeline: arbitrates query channels onto the
// state-table read port and returns the selected entry with a hazard/validity code.
module v_pipe_query_mp
  import v_pipe_query_mp_pkg::*;
#(
  parameter  int QUERY_N      = 2,
  parameter  int UPD_STAGES_N = 4,
  parameter  bit BUSY_STALL   = 1'b0,
  parameter  bit OUT_REG      = 1'b0,
  localparam int CH_W         = (QUERY_N > 1) ? $clog2(QUERY_N) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [QUERY_N-1:0]           i_lut_vld,
  input  logic [QUERY_N*ID_W-1:0]      i_lut_prod_id,
  input  logic [QUERY_N*LEVEL_W-1:0]   i_lut_level,
  output logic [QUERY_N-1:0]           o_lut_rdy,
  output logic                         o_lut_vld_r,
  output logic [CH_W-1:0]              o_lut_ch_r,
  output logic [KEY_W-1:0]             o_lut_key,
  output logic [VOL_W-1:0]             o_lut_size,
  output logic [LS_W-1:0]              o_lut_listsize,
  output logic                         o_lut_error,
  output logic [1:0]                   o_lut_err_code,
  output logic                         o_state_ren,
  output logic [ID_W-1:0]              o_state_raddr,
  input  logic [$bits(state_t)-1:0]    i_state_rdata,
  input  logic [UPD_STAGES_N-1:0]      i_upd_vld_r,
  input  logic [UPD_STAGES_N*ID_W-1:0] i_upd_prod_id_r
);

  state_t               rd_s;
  logic [QUERY_N-1:0]   busy_s, elig_s, gnt_s;
  logic                 gnt_any_s, gnt_busy_s;
  logic [CH_W-1:0]      gnt_idx_s;
  id_t                  gnt_id_s;
  level_t               gnt_lvl_s;

  logic                 s1_vld_q, s1_busy_q;
  logic [CH_W-1:0]      s1_ch_q;
  id_t                  s1_id_q;
  logic [ENTRIES_N-1:0] s1_dec_q;

  logic                 was_busy_s, invalid_s;
  lut_err_t             err_d;
  key_t                 key_d;
  volume_t              vol_d;
  listsize_t            ls_d;

  assign rd_s = i_state_rdata;

  always_comb begin
    busy_s = '0;
    for (int c = 0; c < QUERY_N; c++) begin
      for (int k = 0; k < UPD_STAGES_N; k++) begin
        if (i_upd_vld_r[k] && (i_upd_prod_id_r[k*ID_W +: ID_W] == i_lut_prod_id[c*ID_W +: ID_W])) begin
          busy_s[c] = 1'b1;
        end else begin
          busy_s[c] = busy_s[c];
        end
      end
    end
  end

  assign elig_s = BUSY_STALL ? (i_lut_vld & ~busy_s) : i_lut_vld;

  v_rr_arb #(.N(QUERY_N)) u_arb (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (~rst),
    .req_i (elig_s),
    .gnt_o (gnt_s)
  );

  always_comb begin
    gnt_idx_s  = '0;
    gnt_id_s   = '0;
    gnt_lvl_s  = '0;
    gnt_busy_s = 1'b0;
    for (int c = 0; c < QUERY_N; c++) begin
      if (gnt_s[c]) begin
        gnt_idx_s  = CH_W'(c);
        gnt_id_s   = i_lut_prod_id[c*ID_W +: ID_W];
        gnt_lvl_s  = i_lut_level[c*LEVEL_W +: LEVEL_W];
        gnt_busy_s = busy_s[c];
      end else begin
        gnt_idx_s  = gnt_idx_s;
      end
    end
  end

  assign gnt_any_s     = |gnt_s;
  assign o_lut_rdy     = gnt_s;
  assign o_state_ren   = gnt_any_s;
  assign o_state_raddr = gnt_id_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
    end else begin
      s1_vld_q <= gnt_any_s;
      if (gnt_any_s) begin
        s1_ch_q   <= gnt_idx_s;
        s1_id_q   <= gnt_id_s;
        s1_dec_q  <= level_decode(gnt_lvl_s);
        s1_busy_q <= gnt_busy_s;
      end
    end
  end

  // Youngest update stage is rechecked here: it may have entered during the grant cycle.
  assign was_busy_s = i_upd_vld_r[0] && (i_upd_prod_id_r[ID_W-1:0] == s1_id_q);
  assign invalid_s  = ((s1_dec_q & rd_s.vld) == '0);
  assign key_d      = key_select(rd_s, s1_dec_q);
  assign vol_d      = vol_select(rd_s, s1_dec_q);
  assign ls_d       = rd_s.listsize;

  always_comb begin
    if (!s1_vld_q) begin
      err_d = LUT_ERR_NONE;
    end else if (s1_busy_q || was_busy_s) begin
      err_d = LUT_ERR_BUSY;
    end else if (invalid_s) begin
      err_d = LUT_ERR_INVALID;
    end else begin
      err_d = LUT_ERR_NONE;
    end
  end

  generate
    if (OUT_REG) begin : g_out_reg
      logic            out_vld_q;
      logic [CH_W-1:0] out_ch_q;
      key_t            out_key_q;
      volume_t         out_vol_q;
      listsize_t       out_ls_q;
      lut_err_t        out_err_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          out_vld_q <= 1'b0;
          out_err_q <= LUT_ERR_NONE;
        end else begin
          out_vld_q <= s1_vld_q;
          out_ch_q  <= s1_ch_q;
          out_key_q <= key_d;
          out_vol_q <= vol_d;
          out_ls_q  <= ls_d;
          out_err_q <= err_d;
        end
      end

      assign o_lut_vld_r    = out_vld_q;
      assign o_lut_ch_r     = out_ch_q;
      assign o_lut_key      = out_key_q;
      assign o_lut_size     = out_vol_q;
      assign o_lut_listsize = out_ls_q;
      assign o_lut_err_code = out_err_q;
      assign o_lut_error    = (out_err_q != LUT_ERR_NONE);
    end else begin : g_out_comb
      assign o_lut_vld_r    = s1_vld_q;
      assign o_lut_ch_r     = s1_ch_q;
      assign o_lut_key      = key_d;
      assign o_lut_size     = vol_d;
      assign o_lut_listsize = ls_d;
      assign o_lut_err_code = err_d;
      assign o_lut_error    = (err_d != LUT_ERR_NONE);
    end
  endgenerate

endmodule

// File: tb/tb_v_pipe_query_mp.sv
// Randomized bench: two configurations (plain; busy-stall with output register)
// checked cycle by cycle against a queue-free transaction-level reference model.
module tb_v_pipe_query_mp;
  import v_pipe_query_mp_pkg::*;

  localparam int QN = 2;
  localparam int US = 4;
  localparam int NCYC = 4000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [QN-1:0]         lut_vld [2];
  logic [QN*ID_W-1:0]    lut_id  [2];
  logic [QN*LEVEL_W-1:0] lut_lvl [2];
  logic [US-1:0]         upd_vld;
  logic [US*ID_W-1:0]    upd_id;

  logic [QN-1:0]  rdy    [2];
  logic           vld_r  [2];
  logic [0:0]     ch_r   [2];
  logic [KEY_W-1:0] key  [2];
  logic [VOL_W-1:0] size [2];
  logic [LS_W-1:0]  ls   [2];
  logic           err    [2];
  logic [1:0]     ec     [2];
  logic           ren    [2];
  logic [ID_W-1:0] raddr [2];
  state_t         rdata  [2];

  state_t mem [256];
  int n_checks = 0;
  int n_fail   = 0;

  v_pipe_query_mp #(.QUERY_N(QN), .UPD_STAGES_N(US), .BUSY_STALL(1'b0), .OUT_REG(1'b0)) dut0 (
    .clk(clk), .rst(rst), .i_lut_vld(lut_vld[0]), .i_lut_prod_id(lut_id[0]), .i_lut_level(lut_lvl[0]),
    .o_lut_rdy(rdy[0]), .o_lut_vld_r(vld_r[0]), .o_lut_ch_r(ch_r[0]), .o_lut_key(key[0]),
    .o_lut_size(size[0]), .o_lut_listsize(ls[0]), .o_lut_error(err[0]), .o_lut_err_code(ec[0]),
    .o_state_ren(ren[0]), .o_state_raddr(raddr[0]), .i_state_rdata(rdata[0]),
    .i_upd_vld_r(upd_vld), .i_upd_prod_id_r(upd_id));

  v_pipe_query_mp #(.QUERY_N(QN), .UPD_STAGES_N(US), .BUSY_STALL(1'b1), .OUT_REG(1'b1)) dut1 (
    .clk(clk), .rst(rst), .i_lut_vld(lut_vld[1]), .i_lut_prod_id(lut_id[1]), .i_lut_level(lut_lvl[1]),
    .o_lut_rdy(rdy[1]), .o_lut_vld_r(vld_r[1]), .o_lut_ch_r(ch_r[1]), .o_lut_key(key[1]),
    .o_lut_size(size[1]), .o_lut_listsize(ls[1]), .o_lut_error(err[1]), .o_lut_err_code(ec[1]),
    .o_state_ren(ren[1]), .o_state_raddr(raddr[1]), .i_state_rdata(rdata[1]),
    .i_upd_vld_r(upd_vld), .i_upd_prod_id_r(upd_id));

  // State table: data appears one cycle after the read address.
  always @(posedge clk) begin
    rdata[0] <= mem[raddr[0]];
    rdata[1] <= mem[raddr[1]];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state, one slot per DUT.
  int ptr [2];
  bit p_vld [2];
  int p_ch [2], p_id [2], p_lvl [2];
  bit p_busy [2];
  bit o_vld [2];
  int o_ch [2], o_key [2], o_size [2], o_ls [2], o_ec [2];
  bit granted [2][QN];

  function automatic bit hazard(input int id);
    hazard = 1'b0;
    for (int k = 0; k < US; k++) begin
      if (upd_vld[k] && (int'(upd_id[k*ID_W +: ID_W]) == id)) hazard = 1'b1;
    end
  endfunction

  task automatic model_step(input int m, input bit bs, input bit oreg);
    bit r_vld, e_vld, wb, busyc;
    int r_ch, r_key, r_size, r_ls, r_ec;
    int e_ch, e_key, e_size, e_ls, e_ec;
    int gnt, cid, id;
    state_t ent;
    string t;
    t = $sformatf("d%0d_", m);
    r_vld = p_vld[m]; r_ch = p_ch[m]; r_key = 0; r_size = 0; r_ls = 0; r_ec = 0;
    if (p_vld[m]) begin
      ent    = mem[p_id[m]];
      wb     = upd_vld[0] && (int'(upd_id[ID_W-1:0]) == p_id[m]);
      r_key  = int'(ent.key[p_lvl[m]]);
      r_size = int'(ent.vol[p_lvl[m]]);
      r_ls   = int'(ent.listsize);
      if (p_busy[m] || wb) r_ec = 1;
      else if (!ent.vld[p_lvl[m]]) r_ec = 2;
      else r_ec = 0;
    end
    if (oreg) begin
      e_vld = o_vld[m]; e_ch = o_ch[m]; e_key = o_key[m]; e_size = o_size[m]; e_ls = o_ls[m]; e_ec = o_ec[m];
    end else begin
      e_vld = r_vld; e_ch = r_ch; e_key = r_key; e_size = r_size; e_ls = r_ls; e_ec = r_ec;
    end
    chk({t, "vld_r"}, 32'(vld_r[m]), 32'(e_vld));
    if (e_vld) begin
      chk({t, "ch_r"}, 32'(ch_r[m]), 32'(e_ch));
      chk({t, "key"}, 32'(key[m]), 32'(e_key));
      chk({t, "size"}, 32'(size[m]), 32'(e_size));
      chk({t, "listsize"}, 32'(ls[m]), 32'(e_ls));
      chk({t, "err_code"}, 32'(ec[m]), 32'(e_ec));
      chk({t, "error"}, 32'(err[m]), 32'(e_ec != 0));
    end else begin
      chk({t, "err_code_idle"}, 32'(ec[m]), 32'd0);
    end

    gnt = -1;
    if (!rst) begin
      for (int i = 0; i < QN; i++) begin
        cid   = (ptr[m] + i) % QN;
        busyc = hazard(int'(lut_id[m][cid*ID_W +: ID_W]));
        if (gnt < 0 && lut_vld[m][cid] && !(bs && busyc)) gnt = cid;
      end
    end
    chk({t, "rdy"}, 32'(rdy[m]), (gnt >= 0) ? (32'd1 << gnt) : 32'd0);
    chk({t, "ren"}, 32'(ren[m]), 32'(gnt >= 0));
    if (gnt >= 0) chk({t, "raddr"}, 32'(raddr[m]), 32'(lut_id[m][gnt*ID_W +: ID_W]));
    for (int c = 0; c < QN; c++) granted[m][c] = (gnt == c);

    if (rst) begin
      ptr[m] = 0; p_vld[m] = 1'b0; o_vld[m] = 1'b0;
    end else begin
      o_vld[m] = r_vld; o_ch[m] = r_ch; o_key[m] = r_key; o_size[m] = r_size; o_ls[m] = r_ls; o_ec[m] = r_ec;
      p_vld[m] = (gnt >= 0);
      if (gnt >= 0) begin
        id        = int'(lut_id[m][gnt*ID_W +: ID_W]);
        p_ch[m]   = gnt;
        p_id[m]   = id;
        p_lvl[m]  = int'(lut_lvl[m][gnt*LEVEL_W +: LEVEL_W]);
        p_busy[m] = hazard(id);
        ptr[m]    = (gnt + 1) % QN;
      end
    end
  endtask

  // Held, ungranted requests usually stay put with stable fields; otherwise re-roll.
  task automatic drive_req(input int m);
    for (int c = 0; c < QN; c++) begin
      if (!(lut_vld[m][c] && !granted[m][c] && ($urandom_range(0, 9) != 0))) begin
        lut_vld[m][c]                  = ($urandom_range(0, 3) != 0);
        lut_id[m][c*ID_W +: ID_W]      = 8'($urandom_range(0, 7));
        lut_lvl[m][c*LEVEL_W +: LEVEL_W] = 2'($urandom_range(0, 3));
      end
    end
  endtask

  initial begin
    state_t st;
    for (int a = 0; a < 256; a++) begin
      for (int e = 0; e < ENTRIES_N; e++) begin
        st.key[e] = 8'($urandom);
        st.vol[e] = 8'($urandom);
      end
      st.vld      = 4'($urandom) | 4'($urandom);
      st.listsize = 4'($urandom);
      mem[a] = st;
    end
    for (int m = 0; m < 2; m++) begin
      lut_vld[m] = '0; lut_id[m] = '0; lut_lvl[m] = '0;
      ptr[m] = 0; p_vld[m] = 1'b0; o_vld[m] = 1'b0;
      for (int c = 0; c < QN; c++) granted[m][c] = 1'b0;
    end
    upd_vld = '0;
    upd_id  = '0;
    rst     = 1'b1;
    repeat (2) @(posedge clk);
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      rst = (cyc < 3) || ($urandom_range(0, 63) == 0);
      drive_req(0);
      drive_req(1);
      for (int k = 0; k < US; k++) begin
        upd_vld[k]               = ($urandom_range(0, 2) == 0);
        upd_id[k*ID_W +: ID_W]   = 8'($urandom_range(0, 7));
      end
      #1;
      model_step(0, 1'b0, 1'b0);
      model_step(1, 1'b1, 1'b1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
